// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin encoding, coin values and payout FSM states
package vend_pkg;

    typedef enum logic [1:0] {
        NICKEL  = 2'b00,
        DIME    = 2'b01,
        QUARTER = 2'b10,
        DOLLAR  = 2'b11
    } coin_e;

    localparam int unsigned NICKEL_CENTS  = 5;
    localparam int unsigned DIME_CENTS    = 10;
    localparam int unsigned QUARTER_CENTS = 25;
    localparam int unsigned DOLLAR_CENTS  = 100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_GAP,
        ST_DONE
    } state_e;

    function automatic int unsigned coin_cents(input coin_e c);
        case (c)
            DOLLAR:  return DOLLAR_CENTS;
            QUARTER: return QUARTER_CENTS;
            DIME:    return DIME_CENTS;
            default: return NICKEL_CENTS;
        endcase
    endfunction

endpackage

// File: rtl/coin_pick.sv
// rtl/coin_pick.sv - greedy choice of the largest coin not exceeding the amount owed
module coin_pick
    import vend_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0] remaining_i,
    output coin_e            coin_type_o,
    output logic [WIDTH-1:0] value_o
);

    coin_e pick;

    // Below 5 cents nothing is offered, so NICKEL is a harmless fallback.
    always_comb begin
        pick = NICKEL;
        if (remaining_i >= WIDTH'(DOLLAR_CENTS)) begin
            pick = DOLLAR;
        end else if (remaining_i >= WIDTH'(QUARTER_CENTS)) begin
            pick = QUARTER;
        end else if (remaining_i >= WIDTH'(DIME_CENTS)) begin
            pick = DIME;
        end
        coin_type_o = pick;
        value_o     = WIDTH'(coin_cents(pick));
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - computes change owed and pays it out one coin per hopper handshake
module change_dispenser
    import vend_pkg::*;
#(
    parameter int WIDTH      = 11,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] paid,
    input  logic [WIDTH-1:0] price,
    input  logic             credit,
    input  logic             abort,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    input  logic             coin_ready,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam bit         NO_GAP   = (GAP_CYCLES == 0);
    localparam logic [7:0] GAP_LAST = NO_GAP ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_e           state_q;
    logic [WIDTH-1:0] remaining_q;
    logic [7:0]       gap_cnt_q;
    logic             coin_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] chg_odd;
    logic [WIDTH-1:0] chg_even;

    // Subtract only when paid exceeds price, so the difference never wraps.
    always_comb begin
        chg = '0;
        if (!credit && (paid > price)) begin
            chg = paid - price;
        end
        chg_odd  = chg % WIDTH'(5);
        chg_even = chg - chg_odd;
    end

    coin_e            pick_type;
    logic [WIDTH-1:0] pick_value;
    logic [WIDTH-1:0] rem_after;
    logic             transfer;

    coin_pick #(.WIDTH(WIDTH)) u_coin_pick (
        .remaining_i (remaining_q),
        .coin_type_o (pick_type),
        .value_o     (pick_value)
    );

    assign transfer  = coin_valid_q & coin_ready;
    assign rem_after = remaining_q - pick_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            gap_cnt_q    <= 8'd0;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_q       <= (chg_odd != '0);
                        remaining_q <= chg_even;
                        busy_q      <= 1'b1;
                        if (chg_even != '0) begin
                            state_q      <= ST_OFFER;
                            coin_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_OFFER: begin
                    // A coin accepted alongside abort still counts.
                    if (transfer) begin
                        remaining_q <= rem_after;
                    end
                    if (abort) begin
                        state_q      <= ST_IDLE;
                        coin_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        gap_cnt_q    <= 8'd0;
                    end else if (transfer) begin
                        if (rem_after == '0) begin
                            state_q      <= ST_DONE;
                            coin_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                        end else if (!NO_GAP) begin
                            state_q      <= ST_GAP;
                            coin_valid_q <= 1'b0;
                            gap_cnt_q    <= GAP_LAST;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        gap_cnt_q <= 8'd0;
                    end else if (gap_cnt_q == 8'd0) begin
                        state_q      <= ST_OFFER;
                        coin_valid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coin_valid = coin_valid_q;
    assign coin_type  = coin_valid_q ? pick_type : NICKEL;
    assign remaining  = remaining_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Returns change to the customer after a vend. It is the payout counterpart of the coin-accepting display/credit logic. It takes the settled paid and price totals in cents and computes the change owed. It then pays that change out with greedy coin selection to a coin hopper, one coin per valid/ready handshake, with a programmable settle gap between coins. It sits beside the display block on the same clock domain and is started when the vend light asserts.

## Interface
Parameters:
- `WIDTH`, 11, width of all cent quantities (paid, price, remaining).
- `GAP_CYCLES`, 4, idle cycles inserted after each accepted coin. Legal range is 0..255.

Ports:
- `clk`, in, 1, system clock.
- `rst_n`, in, 1, reset: asynchronous assertion, active-low.
- `start`, in, 1, single-cycle request to compute and pay change. Sampled only in IDLE.
- `paid`, in, WIDTH, cents inserted. Sampled on the `start` edge.
- `price`, in, WIDTH, cents of the selected item. Sampled on the `start` edge.
- `credit`, in, 1, card payment. When 1, change is 0. Sampled on the `start` edge.
- `abort`, in, 1, stops payout and returns to IDLE.
- `coin_valid`, out, 1, coin request to the hopper.
- `coin_type`, out, 2, coin being requested. Encoding is in the package.
- `coin_ready`, in, 1, hopper accepts the coin this cycle.
- `remaining`, out, WIDTH, cents still to pay.
- `busy`, out, 1, high in any state other than IDLE.
- `done`, out, 1, one-cycle pulse when payout completes.
- `err`, out, 1, change was not a multiple of 5 and the remainder was forfeited. Sticky until the next accepted `start`.

## Operation
- States are IDLE, OFFER, GAP and DONE.
- **Start in IDLE.** When `start`=1, capture `chg` as follows:
  - `chg` = 0 if `credit`=1 or `paid` <= `price`.
  - Otherwise `chg` = `paid` − `price`.
  - `err` <= (`chg` mod 5 != 0).
  - `remaining` <= `chg` − (`chg` mod 5).
  - Next state is OFFER if `remaining` != 0, else DONE.
- **Start ignored.** `start` is ignored outside IDLE. `paid`, `price` and `credit` are don't-care outside the start cycle.
- **OFFER.** `coin_valid`=1 and `coin_type` = largest coin whose value <= `remaining`. Candidate values are 100, 25, 10 and 5.
  - `coin_type` and `remaining` hold stable while `coin_ready`=0. There is no timeout.
- **Transfer.** A transfer is `coin_valid` && `coin_ready`. On a transfer:
  - `remaining` <= `remaining` − coin value.
  - If the new `remaining` is 0, go to DONE.
  - Otherwise go to GAP, or straight to OFFER if `GAP_CYCLES`=0.
- **GAP.** Count `GAP_CYCLES` cycles with `coin_valid`=0, then go to OFFER.
- **DONE.** `done`=1 for exactly one cycle, then IDLE.
- **abort.** Takes priority over all transitions in every non-IDLE state.
  - The next state is IDLE with no `done` pulse and `coin_valid` low.
  - If `abort` and a transfer coincide, the coin counts and `remaining` is decremented before returning to IDLE. `remaining` keeps the unpaid amount.
  - `abort` in IDLE has no effect.
- **Arithmetic.** Subtraction is unsigned WIDTH-bit and is performed only when `paid` > `price`, so it never wraps. The maximum change of 2047 rounds down to 2045.
- **Reset values.** State is IDLE. `coin_valid`, `coin_type`, `remaining`, `busy`, `done` and `err` are all 0. The gap counter is 0.
- **Reset mid-payout.** Outputs drop to reset values immediately and asynchronously. A transfer in flight at that moment is not counted.

## Timing
- Let edge N be the edge that samples `start`.
- **Change owed.** `coin_valid` is high from cycle N+1.
- **No change owed.** `done` is high in cycle N+1 and `busy` is low from N+2.
- **Back-to-back coins.** For a transfer at edge M, the next `coin_valid` is high at cycle M+1+`GAP_CYCLES`.
- **Final coin.** A transfer at edge M on the final coin gives `done` in cycle M+1.
- **Registered outputs.** All outputs are registered. `coin_type` is the exception: it may be decoded from the registered `remaining`, but it must be glitch-free relative to `clk`.
- **New start.** A `start` in the same cycle as `done` is ignored. The earliest new `start` is in the first IDLE cycle.

## Structure
- Package `vend_pkg` holds:
  - The coin encoding: NICKEL=2'b00, DIME=2'b01, QUARTER=2'b10, DOLLAR=2'b11.
  - The coin values 5, 10, 25 and 100.
  - The state enum.
- Sub-module `coin_pick`: combinational, maps `remaining` to (`coin_type`, value) using the greedy order.
- The top level holds the FSM, the gap counter and the captured registers.

## Test plan
- `paid`=200, `price`=120, `GAP_CYCLES`=2, `coin_ready`=1 -> coins QUARTER, QUARTER, QUARTER, NICKEL. Each `coin_valid` rise is 3 cycles after the previous transfer. `done` comes after the 4th coin, `remaining`=0 and `err`=0.
- `paid`=100, `price`=120, and separately `credit`=1, `paid`=1515 -> no `coin_valid` ever. `done` is high in N+1 and `remaining`=0.
- `paid`=167, `price`=120 -> `err`=1 and `remaining`=45. Coins are QUARTER, DIME, DIME, then `done`.
- `paid`=300, `price`=55, with `coin_ready` held low 5 cycles on the first offer -> `coin_valid`=1 and `coin_type`=DOLLAR held stable. Full sequence is DOLLAR, DOLLAR, QUARTER, DIME, DIME.
- Abort and reset:
  - `abort` during GAP after the first coin of a 245-cent change -> IDLE next cycle, no `done`, `remaining`=145.
  - `abort` coincident with a transfer -> `remaining` is decremented.
  - `rst_n` low mid-OFFER -> all outputs 0 immediately.
- `start` pulsed while busy -> ignored. The original payout completes unchanged.
